// File: rtl/pio_leds_pkg.sv
// Shared register-map constants for the LED output PIO.
package pio_leds_pkg;

    // Word addresses of the slave registers
    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN  = 3'd1;
    localparam logic [2:0] ADDR_BLINK_DIV = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

    // Bit position of the blink phase in the STATUS register
    localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/pio_leds_out_prescaler.sv
// Blink prescaler: counts down a half-period of (div+1) clocks and toggles phase.
// div==0 disables blinking and pins phase high.
module blink_prescaler #(
    parameter int unsigned DIV_WIDTH   = 26,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 load,
    output logic                 phase
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_phase;

    // Down-counter with reload; load restarts the period in the high phase
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= DIV_WIDTH'(DEFAULT_DIV);
            r_phase <= 1'b1;
        end else if (load) begin
            r_cnt   <= div;
            r_phase <= 1'b1;
        end else if (div == '0) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == '0) begin
            r_cnt   <= div;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/pio_leds_out.sv
// Avalon-MM output PIO driving board LEDs, with atomic set/clear and
// per-bit hardware blinking.
module pio_leds_out
    import pio_leds_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned DIV_WIDTH   = 26,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]     r_data_reg;
    logic [WIDTH-1:0]     r_blink_en;
    logic [DIV_WIDTH-1:0] r_blink_div;
    logic [31:0]          r_readdata;
    logic [WIDTH-1:0]     r_out_port;

    logic                 w_write;
    logic                 w_load;
    logic                 w_phase;
    logic [DIV_WIDTH-1:0] w_div_in;
    logic [31:0]          w_rd_mux;
    logic                 w_unused_wdata;

    assign w_write        = chipselect & ~write_n;
    assign w_load         = w_write && (address == ADDR_BLINK_DIV);
    // The prescaler sees the incoming divisor on the load edge so the
    // restarted period uses the new value immediately.
    assign w_div_in       = w_load ? writedata[DIV_WIDTH-1:0] : r_blink_div;
    assign w_unused_wdata = ^writedata;

    blink_prescaler #(
        .DIV_WIDTH  (DIV_WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .div    (w_div_in),
        .load   (w_load),
        .phase  (w_phase)
    );

    // Register file writes, including single-edge read-modify-write set/clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_reg  <= '0;
            r_blink_en  <= '0;
            r_blink_div <= DIV_WIDTH'(DEFAULT_DIV);
        end else if (w_write) begin
            case (address)
                ADDR_DATA:      r_data_reg  <= writedata[WIDTH-1:0];
                ADDR_BLINK_EN:  r_blink_en  <= writedata[WIDTH-1:0];
                ADDR_BLINK_DIV: r_blink_div <= writedata[DIV_WIDTH-1:0];
                ADDR_OUTSET:    r_data_reg  <= r_data_reg | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR:  r_data_reg  <= r_data_reg & ~writedata[WIDTH-1:0];
                default:        ;
            endcase
        end
    end

    // Read mux over current register values; write-only and reserved read 0
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:      w_rd_mux = 32'(r_data_reg);
            ADDR_BLINK_EN:  w_rd_mux = 32'(r_blink_en);
            ADDR_BLINK_DIV: w_rd_mux = 32'(r_blink_div);
            ADDR_STATUS:    w_rd_mux[STATUS_PHASE_BIT] = w_phase;
            default:        w_rd_mux = '0;
        endcase
    end

    // Registered read data, sampled every cycle regardless of chipselect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    // Registered LED drive: blinking bits are masked off in the low phase
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_port <= '0;
        end else begin
            r_out_port <= r_data_reg & ~(r_blink_en & {WIDTH{~w_phase}});
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out_port;

endmodule

// File: tb/tb_pio_leds_out.sv
// Self-checking bench for pio_leds_out against a behavioural model.
module tb_pio_leds_out;

    localparam int WIDTH     = 10;
    localparam int DIV_WIDTH = 26;
    localparam int unsigned DEF_DIV = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    always #5 clk = ~clk;

    pio_leds_out #(
        .WIDTH      (WIDTH),
        .DIV_WIDTH  (DIV_WIDTH),
        .DEFAULT_DIV(DEF_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    int checks = 0;
    int errors = 0;

    // Model state: registers plus number of edges since the last period restart
    logic [WIDTH-1:0]     m_data;
    logic [WIDTH-1:0]     m_en;
    logic [DIV_WIDTH-1:0] m_div;
    int unsigned          m_n;
    logic [31:0]          m_rd;
    logic [WIDTH-1:0]     m_out;

    // Phase from elapsed time: high for div+1 clocks, low for div+1, ...
    function automatic logic m_phase();
        int unsigned hp;
        if (m_div == '0) return 1'b1;
        hp = int'(m_div) + 1;
        return ((m_n / hp) % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = '0;
        m_en   = '0;
        m_div  = DIV_WIDTH'(DEF_DIV);
        m_n    = 0;
        m_rd   = '0;
        m_out  = '0;
    endtask

    // One clock: predict, let the edge pass, update model, compare outputs
    task automatic cycle();
        logic             ph;
        logic [31:0]      rd_n;
        logic [WIDTH-1:0] out_n;
        logic             loaded;
        ph    = m_phase();
        out_n = m_data & ~(m_en & {WIDTH{~ph}});
        case (address)
            3'd0:    rd_n = 32'(m_data);
            3'd1:    rd_n = 32'(m_en);
            3'd2:    rd_n = 32'(m_div);
            3'd3:    rd_n = {31'd0, ph};
            default: rd_n = 32'd0;
        endcase
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_rd   = rd_n;
            m_out  = out_n;
            loaded = 1'b0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[WIDTH-1:0];
                    3'd1: m_en   = writedata[WIDTH-1:0];
                    3'd2: begin m_div = writedata[DIV_WIDTH-1:0]; m_n = 0; loaded = 1'b1; end
                    3'd4: m_data = m_data | writedata[WIDTH-1:0];
                    3'd5: m_data = m_data & ~writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
            if (!loaded) m_n++;
        end
        chk("readdata", readdata, m_rd);
        chk("out_port", 32'(out_port), 32'(m_out));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input logic [2:0] a);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        cycle();
    endtask

    initial begin
        model_reset();
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'hFFFF_FFFF;

        // Reset held with writes active
        repeat (3) cycle();
        chk("rst_rd", readdata, 32'd0);
        chk("rst_out", 32'(out_port), 32'd0);
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        idle(3'd2);
        idle(3'd2);
        chk("rst_div", readdata, 32'(DEF_DIV));

        // DATA write with junk in the upper bits
        wr(3'd0, 32'hFFFF_FC00 | 32'h2A5);
        idle(3'd0);
        idle(3'd0);
        chk("data_out", 32'(out_port), 32'h2A5);
        chk("data_rd", readdata, 32'h0000_02A5);

        // Back-to-back set then clear
        wr(3'd4, 32'h003);
        wr(3'd5, 32'h201);
        idle(3'd0);
        chk("setclr_rd", readdata, 32'h0A6);
        idle(3'd4);
        chk("outset_rd0", readdata, 32'd0);
        idle(3'd5);
        chk("outclr_rd0", readdata, 32'd0);

        // Blink: period restart on BLINK_DIV write, 4-clock half-period
        wr(3'd0, 32'h00F);
        wr(3'd1, 32'h005);
        wr(3'd2, 32'd3);
        for (int k = 1; k <= 16; k++) begin
            idle(3'd3);
            chk("blink_out", 32'(out_port), (((k - 1) / 4) % 2 == 0) ? 32'h00F : 32'h00A);
            chk("blink_status", readdata, (((k - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Mid-blink reset
        repeat (5) idle(3'd3);
        reset_n = 1'b0;
        wr(3'd0, 32'h3FF);
        chk("midrst_out", 32'(out_port), 32'd0);
        reset_n = 1'b1;
        idle(3'd3);
        idle(3'd3);
        chk("midrst_phase", readdata, 32'd1);

        // Blinking disabled by divisor 0
        wr(3'd1, 32'h3FF);
        wr(3'd0, 32'h3FF);
        wr(3'd2, 32'd0);
        for (int k = 0; k < 12; k++) begin
            idle(3'd3);
            chk("div0_out", 32'(out_port), 32'h3FF);
            chk("div0_status", readdata, 32'd1);
        end

        // chipselect low ignores the write strobe
        address    = 3'd0;
        writedata  = 32'h0000_0055;
        chipselect = 1'b0;
        write_n    = 1'b0;
        cycle();
        write_n = 1'b1;
        idle(3'd0);
        chk("cs0_rd", readdata, 32'h3FF);

        // Randomized traffic with occasional resets and short divisors
        for (int i = 0; i < 600; i++) begin
            reset_n    = ($urandom_range(0, 59) != 0);
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) == 0);
            writedata  = $urandom;
            if (address == 3'd2)
                writedata = (writedata & 32'hFC00_0000) | 32'($urandom_range(0, 6));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_leds_out.md
Name: pio_leds_out

Overview:
- Avalon-MM slave output PIO: the write-direction counterpart to the switch input PIO.
- Drives board LEDs (LEDR) from a CPU-writable data register.
- Supports atomic bit set/clear and per-bit hardware blinking from an on-block prescaler.
- Sits on the HPS/Nios lightweight bus next to the switch PIO.
- readdata is registered and sampled every cycle, one cycle of latency.

Parameters:
- WIDTH, 10, number of output bits (LEDR[9:0]).
- DIV_WIDTH, 26, width of prescaler counter and BLINK_DIV register.
- DEFAULT_DIV, 25000000, BLINK_DIV reset value (0.5 s half-period at 50 MHz).

Ports:
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk.
- address  in  3  word address of register.
- chipselect  in  1  slave select; writes ignored when 0.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above register width ignored.
- readdata  out  32  registered read data; unused upper bits 0.
- out_port  out  WIDTH  registered LED drive.

Behaviour:
- Reset and clocking: one clock, clk; reset_n is synchronous and active-low. All state changes on rising clk.
- Reset values:
  - data_reg=0, blink_en=0, blink_div=DEFAULT_DIV.
  - cnt=DEFAULT_DIV, phase=1.
  - readdata=0, out_port=0.
- Register map (address):
  - 0 DATA R/W: data_reg.
  - 1 BLINK_EN R/W: per-bit blink mask.
  - 2 BLINK_DIV R/W: half-period in clocks, DIV_WIDTH bits.
  - 3 STATUS R: bit0=phase, others 0; writes ignored.
  - 4 OUTSET W: data_reg <= data_reg | writedata[WIDTH-1:0]; reads return 0.
  - 5 OUTCLEAR W: data_reg <= data_reg & ~writedata[WIDTH-1:0]; reads return 0.
  - 6,7 reserved: reads 0, writes ignored.
- Write accepted at an edge where chipselect=1 and write_n=0; register updates at that edge. No wait states.
- Read: readdata <= mux(address) every cycle (chipselect not required), so it reflects register values before that edge.
  - A read on the same edge as a write to the same register returns the old value.
- Prescaler:
  - If blink_div==0: cnt holds 0 and phase forced 1 (blinking disabled, blink bits steady on).
  - Otherwise cnt decrements each cycle. At cnt==0 it reloads blink_div and toggles phase.
  - Half-period = blink_div+1 clocks.
- A BLINK_DIV write loads cnt <= new value and sets phase <= 1 at the same edge, restarting the period.
- out_port <= data_reg & ~(blink_en & {WIDTH{~phase}}). Registered, so a DATA write shows on out_port one edge after the register updates.
- Simultaneous write and phase toggle: both take effect; out_port next edge uses new data_reg and new phase.
- OUTSET/OUTCLEAR are read-modify-write in one edge; no lost updates.
- Reset asserted mid-operation: next edge restores all reset values regardless of write or counter state. Counter restarts from DEFAULT_DIV.

Decomposition:
- Shared package pio_leds_pkg:
  - address constants ADDR_DATA=0, ADDR_BLINK_EN=1, ADDR_BLINK_DIV=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5;
  - STATUS_PHASE_BIT=0.
- One sub-module blink_prescaler, parameters DIV_WIDTH and DEFAULT_DIV:
  - inputs clk, reset_n, div, load;
  - output phase.
  - Contains cnt and the toggle logic.
- Top holds the register file, read mux and output register.

Test Plan:
- Reset: hold reset_n=0 three cycles with writes active -> readdata=0, out_port=0, a read of BLINK_DIV returns DEFAULT_DIV.
- DATA write 0x2A5 at addr 0 -> out_port=0x2A5 two edges after the write edge; read addr 0 -> 0x000002A5; writedata 0xFFFFFC00 upper bits have no effect.
- OUTSET 0x003 then OUTCLEAR 0x201 on back-to-back cycles, starting from 0x2A5 -> data_reg 0x2A7 then 0x0A6; read addr 4/5 -> 0.
- Blink with DEFAULT_DIV overridden to 4:
  - DATA=0x00F, BLINK_EN=0x005, then write BLINK_DIV=3 -> out_port alternates 0x00F / 0x00A every 4 clocks;
  - STATUS bit0 tracks phase.
- BLINK_DIV=0 with BLINK_EN=0x3FF, DATA=0x3FF -> out_port steady 0x3FF, STATUS=1.
- chipselect=0 with write_n=0 to addr 0 -> no change. Assert reset_n=0 mid-blink -> next edge out_port=0, phase=1, counter restarts.
